// File: rtl/dma_controller.sv
// Bus-master DMA engine: copies a device buffer into D-memory as
// FETCH_SIZE-wide bursts once the D-cache grants the shared bus.
module dma_controller #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned FETCH_SIZE  = 64,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dma_start,
  input  logic [WORD_SIZE-1:0]  dma_addr,
  input  logic [WORD_SIZE-1:0]  dma_len,
  input  logic                  BG,
  input  logic [FETCH_SIZE-1:0] dev_data,
  output logic                  BR,
  output logic [WORD_SIZE-1:0]  dev_offset,
  output logic                  d_writeM,
  output logic [WORD_SIZE-1:0]  d_addressM,
  output logic [FETCH_SIZE-1:0] d_dataM,
  output logic                  dma_busy,
  output logic                  dma_end,
  output logic [3:0]            dma_counter
);

  localparam int unsigned WPB     = FETCH_SIZE / WORD_SIZE;
  localparam int unsigned LEN_W   = WORD_SIZE + 1;
  localparam int unsigned CYC_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_cyc_last;
  logic                 w_last_burst;
  logic                 w_drive;
  logic [WORD_SIZE-1:0] w_nbursts;

  logic                 r_own;
  logic                 r_end;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_offset;
  logic [WORD_SIZE-1:0] r_left;
  logic [CYC_W-1:0]     r_cyc;
  logic [CNT_W-1:0]     r_counter;

  // Word index within the transfer, clamped to the 4-bit counter range.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [LEN_W-1:0] v);
    return (v > LEN_W'(CNT_MAX)) ? CNT_W'(CNT_MAX) : v[CNT_W-1:0];
  endfunction

  assign w_nbursts    = WORD_SIZE'((LEN_W'(dma_len) + LEN_W'(WPB - 1)) / LEN_W'(WPB));
  assign w_cyc_last   = (r_cyc == CYC_W'(MEM_LATENCY - 1));
  assign w_last_burst = (r_left == WORD_SIZE'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; a lost grant in XFER falls back to REQ.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dma_start) begin
          w_accept = 1'b1;
          w_next   = (dma_len == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (BG) w_next = ST_XFER;
      end
      ST_XFER: begin
        if (!BG)                            w_next = ST_REQ;
        else if (w_cyc_last && w_last_burst) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered handshake outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_own <= 1'b0;
      r_end <= 1'b0;
    end else begin
      r_own <= (w_next == ST_REQ) || (w_next == ST_XFER);
      r_end <= (w_next == ST_DONE);
    end
  end

  // Burst address, device offset, remaining bursts and beat counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_offset  <= '0;
      r_left    <= '0;
      r_cyc     <= '0;
      r_counter <= '0;
    end else if (w_accept) begin
      r_addr    <= dma_addr;
      r_offset  <= '0;
      r_left    <= w_nbursts;
      r_cyc     <= '0;
      r_counter <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (BG) begin
            r_cyc     <= '0;
            r_counter <= sat_cnt(LEN_W'(r_offset));
          end
        end
        ST_XFER: begin
          if (!BG) begin
            r_cyc <= '0;
          end else if (w_cyc_last) begin
            r_cyc <= '0;
            if (!w_last_burst) begin
              r_addr    <= r_addr + WORD_SIZE'(WPB);
              r_offset  <= r_offset + WORD_SIZE'(WPB);
              r_left    <= r_left - WORD_SIZE'(1);
              r_counter <= sat_cnt(LEN_W'(r_offset) + LEN_W'(WPB));
            end
          end else begin
            r_cyc     <= r_cyc + CYC_W'(1);
            r_counter <= sat_cnt(LEN_W'(r_offset) + LEN_W'(r_cyc) + LEN_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Bus is released the same cycle the grant drops.
  assign w_drive = (r_state == ST_XFER) && BG;

  assign d_writeM    = w_drive ? 1'b1     : 1'bz;
  assign d_addressM  = w_drive ? r_addr   : {WORD_SIZE{1'bz}};
  assign d_dataM     = w_drive ? dev_data : {FETCH_SIZE{1'bz}};
  assign BR          = r_own;
  assign dma_busy    = r_own;
  assign dma_end     = r_end;
  assign dev_offset  = r_offset;
  assign dma_counter = r_counter;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: stimulus queues expected bursts
// and completions, a monitor pops and compares what appears on the bus.
module tb_dma_controller;

  localparam int unsigned WS  = 16;
  localparam int unsigned FS  = 64;
  localparam int unsigned ML  = 4;
  localparam int unsigned WPB = FS / WS;
  localparam logic [80:0] BUS_IDLE = {1'b0, {WS{1'b1}}, {FS{1'b1}}};

  typedef struct {
    logic [15:0] addr;
    int          k;
    int          len;
  } run_t;

  typedef struct {
    logic [3:0] cnt;
    bit         had_data;
  } end_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_start;
  logic [15:0] dma_addr;
  logic [15:0] dma_len;
  logic        BG;
  logic [63:0] dev_data;
  logic [15:0] dev_seed;
  logic        bg_auto;
  logic        bg_man;
  logic        bg_hold;
  logic        br_d = 1'b0;

  wire         BR;
  wire  [15:0] dev_offset;
  tri0         d_writeM;
  tri1  [15:0] d_addressM;
  tri1  [63:0] d_dataM;
  wire         dma_busy;
  wire         dma_end;
  wire  [3:0]  dma_counter;

  int errors = 0;
  int checks = 0;

  run_t exp_q[$];
  end_t end_q[$];

  dma_controller #(.WORD_SIZE(WS), .FETCH_SIZE(FS), .MEM_LATENCY(ML)) dut (
    .clk(clk), .reset_n(reset_n), .dma_start(dma_start), .dma_addr(dma_addr),
    .dma_len(dma_len), .BG(BG), .dev_data(dev_data), .BR(BR),
    .dev_offset(dev_offset), .d_writeM(d_writeM), .d_addressM(d_addressM),
    .d_dataM(d_dataM), .dma_busy(dma_busy), .dma_end(dma_end),
    .dma_counter(dma_counter)
  );

  always #5 clk = ~clk;

  // Grant follows request one cycle late unless held off or driven manually.
  always @(posedge clk) br_d <= BR;
  assign BG = bg_auto ? (br_d & ~bg_hold) : bg_man;

  function automatic logic [63:0] dev_fn(input logic [15:0] off, input logic [15:0] s);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = (off + 16'(i)) ^ s;
    return r;
  endfunction

  assign dev_data = dev_fn(dev_offset, dev_seed);

  function automatic logic [3:0] exp_cnt(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_run(input logic [15:0] addr, input int k, input int len);
    run_t r;
    r.addr = 16'(int'(addr) + 4 * k);
    r.k    = k;
    r.len  = len;
    exp_q.push_back(r);
  endtask

  // Reference model: one full run per burst, optional aborted prefix run.
  task automatic plan(input logic [15:0] addr, input int len, input int abort_k, input int abort_len);
    int   n;
    end_t e;
    n = (len + int'(WPB) - 1) / int'(WPB);
    for (int k = 0; k < n; k++) begin
      if (k == abort_k) push_run(addr, k, abort_len);
      push_run(addr, k, int'(ML));
    end
    e.cnt      = (len == 0) ? 4'd0 : exp_cnt(n * int'(WPB) - 1);
    e.had_data = (len != 0);
    end_q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    dma_addr  = addr;
    dma_len   = len;
    dma_start = 1'b1;
    @(posedge clk); #1;
    dma_start = 1'b0;
    dma_addr  = 16'($urandom);
    dma_len   = 16'($urandom);
    if (len != 0) chk("accept_br_busy", 96'({BR, dma_busy, dma_end}), 96'(3'b110));
    else          chk("accept_len0",    96'({BR, dma_busy, dma_end}), 96'(3'b001));
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (dma_end !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (dma_end !== 1'b1) fail("timeout_end");
  endtask

  task automatic wait_write(input logic [15:0] addr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d_writeM === 1'b1 && d_addressM === addr) && n < 200);
    if (!(d_writeM === 1'b1 && d_addressM === addr)) fail("timeout_write");
  endtask

  task automatic finish_xfer();
    @(posedge clk); #1;
    chk("end_pulse_width", 96'(dma_end), 96'(1'b0));
    chk("sb_runs_left", 96'(exp_q.size()), 96'(0));
    chk("sb_ends_left", 96'(end_q.size()), 96'(0));
  endtask

  task automatic xfer_auto(input logic [15:0] addr, input logic [15:0] len);
    int n;
    int nb;
    nb = (int'(len) + int'(WPB) - 1) / int'(WPB);
    plan(addr, int'(len), -1, 0);
    issue(addr, len);
    wait_end(n);
    chk("latency", 96'(n), 96'((len == 0) ? 0 : nb * int'(ML) + 2));
    finish_xfer();
  endtask

  // Monitor: every write cycle belongs to the run at the head of the queue.
  run_t cur;
  end_t ecur;
  int   mc      = 0;
  bit   in_run  = 1'b0;
  bit   prev_wr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (d_writeM === 1'b1) begin
        if (!in_run || mc == cur.len) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_write");
            cur.addr = 16'hxxxx;
            cur.k    = 0;
            cur.len  = 1 << 20;
          end else begin
            cur = exp_q.pop_front();
          end
          in_run = 1'b1;
          mc     = 0;
        end
        chk("wr_addr",    96'(d_addressM),  96'(cur.addr));
        chk("wr_data",    96'(d_dataM),     96'(dev_fn(16'(4 * cur.k), dev_seed)));
        chk("wr_counter", 96'(dma_counter), 96'(exp_cnt(4 * cur.k + mc)));
        mc++;
      end else begin
        if (in_run) chk("run_length", 96'(mc), 96'(cur.len));
        in_run = 1'b0;
        chk("bus_released", 96'({d_writeM, d_addressM, d_dataM}), 96'(BUS_IDLE));
      end
      if (dma_end === 1'b1) begin
        if (end_q.size() == 0) begin
          fail("unexpected_end");
        end else begin
          ecur = end_q.pop_front();
          chk("end_br_busy",     96'({BR, dma_busy}), 96'(2'b00));
          chk("end_counter",     96'(dma_counter),    96'(ecur.cnt));
          chk("end_after_write", 96'(prev_wr),        96'(ecur.had_data));
        end
      end
      prev_wr = (d_writeM === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] a;
    logic [15:0] l;

    reset_n   = 1'b0;
    dma_start = 1'b0;
    dma_addr  = '0;
    dma_len   = '0;
    dev_seed  = 16'h5A3C;
    bg_auto   = 1'b1;
    bg_man    = 1'b0;
    bg_hold   = 1'b0;

    #3;
    chk("reset_outputs", 96'({BR, dma_busy, dma_end, dma_counter, dev_offset}), 96'(0));
    chk("reset_bus", 96'({d_writeM, d_addressM, d_dataM}), 96'(BUS_IDLE));
    #20 reset_n = 1'b1;

    // Nominal three-burst transfer.
    xfer_auto(16'h0100, 16'd12);

    // Length corner cases and address wrap.
    xfer_auto(16'h4444, 16'd0);
    xfer_auto(16'h1230, 16'd5);
    xfer_auto(16'hFFFC, 16'd8);

    // Grant withheld for 20 cycles, then granted manually.
    bg_auto = 1'b0;
    bg_man  = 1'b0;
    plan(16'h2468, 8, -1, 0);
    issue(16'h2468, 16'd8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("withheld_br", 96'({BR, d_writeM}), 96'(2'b10));
    end
    @(posedge clk); #1;
    bg_man = 1'b1;
    #1 chk("grant_not_yet", 96'(d_writeM), 96'(1'b0));
    @(posedge clk); #1;
    chk("grant_first_write", 96'({d_writeM, d_addressM}), 96'({1'b1, 16'h2468}));
    wait_end(n);
    chk("withheld_latency", 96'(n), 96'(8));
    finish_xfer();
    bg_man  = 1'b0;
    bg_auto = 1'b1;

    // Grant revoked in cycle 2 of burst 1.
    plan(16'h0A00, 12, 1, 2);
    issue(16'h0A00, 16'd12);
    wait_write(16'h0A04);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bg_hold = 1'b1;
    #1 chk("revoke_bus_z", 96'({d_writeM, BR}), 96'(2'b01));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("revoke_hold", 96'({BR, d_writeM, dma_counter}), 96'({1'b1, 1'b0, 4'd6}));
    end
    bg_hold = 1'b0;
    wait_end(n);
    chk("revoke_latency", 96'(n), 96'(9));
    finish_xfer();

    // Start strobe while busy must be ignored.
    plan(16'h0300, 12, -1, 0);
    issue(16'h0300, 16'd12);
    repeat (6) begin @(posedge clk); #1; end
    dma_start = 1'b1;
    dma_addr  = 16'h0200;
    dma_len   = 16'd4;
    @(posedge clk); #1;
    dma_start = 1'b0;
    wait_end(n);
    chk("busy_latency", 96'(n), 96'(7));
    repeat (4) begin @(posedge clk); #1; end
    finish_xfer();

    // Reset in the middle of a burst, then a fresh command.
    push_run(16'h7000, 0, 1);
    issue(16'h7000, 16'd8);
    wait_write(16'h7000);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 96'({BR, dma_busy, dma_end, dma_counter, dev_offset}), 96'(0));
    chk("reset_mid_bus", 96'({d_writeM, d_addressM, d_dataM}), 96'(BUS_IDLE));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_no_end", 96'(end_q.size()), 96'(0));
    xfer_auto(16'h7000, 16'd8);

    // Randomized transfers, with a bias toward the top of the address space.
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFFF0 + 16'($urandom_range(0, 15));
      l = 16'($urandom_range(0, 40));
      dev_seed = 16'($urandom);
      xfer_auto(a, l);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
